// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes ALU control into a registered op code and sequences multi-cycle MUL/DIV/REM ops
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int ENABLE_M = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  input  logic [2:0] alu_op_i,
  output logic [3:0] alu_operation_o,
  output logic       op_valid_o,
  output logic       busy_o,
  output logic       illegal_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] op_q, op_n, base_op, dec_op;
  logic ill_q, ill_n, vld_q, vld_n, dec_ill, dec_multi, accept;
  always_comb begin
    case (funct3_i)
      3'b000: base_op = 4'b0000;
      3'b001: base_op = 4'b0101;
      3'b010: base_op = 4'b1000;
      3'b011: base_op = 4'b1001;
      3'b100: base_op = 4'b0011;
      3'b101: base_op = 4'b0110;
      3'b110: base_op = 4'b0001;
      default: base_op = 4'b0010;
    endcase
  end
  always_comb begin
    dec_op = 4'b0000;
    dec_ill = 1'b0;
    case (alu_op_i)
      3'b000:
        if (funct7_i == 7'b0000000) dec_op = base_op;
        else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) dec_op = 4'b0100;
        else if (funct7_i == 7'b0100000 && funct3_i == 3'b101) dec_op = 4'b0111;
        else if (funct7_i == 7'b0000001 && ENABLE_M != 0)
          dec_op = !funct3_i[2] ? 4'b1100 : funct3_i[1] ? 4'b1110 : 4'b1101;
        else dec_ill = 1'b1;
      3'b001:
        if (funct3_i == 3'b101 && funct7_i == 7'b0100000) dec_op = 4'b0111;
        else if (funct3_i[1:0] == 2'b01 && funct7_i != 7'b0000000) dec_ill = 1'b1;
        else dec_op = base_op;
      3'b010, 3'b100: dec_op = 4'b0000;
      3'b011: dec_op = 4'b0100;
      default: dec_ill = 1'b1;
    endcase
  end
  assign dec_multi = dec_op[3:2] == 2'b11;
  assign ready_o = state != BUSY;
  assign busy_o = state == BUSY;
  assign accept = valid_i && ready_o && !flush_i;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    op_n = op_q;
    ill_n = ill_q;
    vld_n = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
      cnt_n = 8'd0;
    end else if (accept) begin
      op_n = dec_op;
      ill_n = dec_ill;
      state_n = dec_multi ? BUSY : IDLE;
      cnt_n = !dec_multi ? cnt : dec_op == 4'b1100 ? MUL_LOAD : DIV_LOAD;
      vld_n = !dec_multi;
    end else if (state == BUSY) begin
      state_n = cnt == 8'd0 ? DONE : BUSY;
      cnt_n = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
      vld_n = cnt == 8'd0;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      op_q <= 4'b0000;
      ill_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_q <= op_n;
      ill_q <= ill_n;
      vld_q <= vld_n;
    end
  end
  assign alu_operation_o = op_q;
  assign illegal_o = ill_q;
  assign op_valid_o = vld_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks against a cycle-countdown reference model
module tb_alu_op_sequencer;
  logic clk = 1'b0, reset = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [6:0] funct7_i = '0;
  logic [2:0] funct3_i = '0, alu_op_i = '0;
  logic ready_o, op_valid_o, busy_o, illegal_o;
  logic [3:0] alu_operation_o;
  logic r2, v2, b2, i2;
  logic [3:0] c2;
  int compared = 0, mismatched = 0;
  logic [3:0] m_code = 0;
  bit m_ill = 0, m_vld = 0;
  int m_left = 0;
  logic [3:0] tbl [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h3, 4'h6, 4'h1, 4'h2};

  always #5 clk = ~clk;

  alu_op_sequencer dut (.clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .alu_op_i(alu_op_i), .alu_operation_o(alu_operation_o),
    .op_valid_o(op_valid_o), .busy_o(busy_o), .illegal_o(illegal_o));

  alu_op_sequencer #(.ENABLE_M(0)) dut_nom (.clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(r2), .funct7_i(funct7_i), .funct3_i(funct3_i), .alu_op_i(alu_op_i), .alu_operation_o(c2),
    .op_valid_o(v2), .busy_o(b2), .illegal_o(i2));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_dec(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                  output logic [3:0] code, output bit ill, output int cyc);
    code = 0; ill = 0; cyc = 0;
    if (op == 3'd2 || op == 3'd4) code = 4'h0;
    else if (op == 3'd3) code = 4'h4;
    else if (op == 3'd0 && f7 == 7'h00) code = tbl[f3];
    else if (op == 3'd0 && f7 == 7'h20 && f3 == 3'd0) code = 4'h4;
    else if (op == 3'd0 && f7 == 7'h20 && f3 == 3'd5) code = 4'h7;
    else if (op == 3'd0 && f7 == 7'h01) begin
      code = f3 < 4 ? 4'hC : f3 < 6 ? 4'hD : 4'hE;
      cyc = f3 < 4 ? 4 : 32;
    end
    else if (op == 3'd1 && f3 == 3'd5 && f7 == 7'h20) code = 4'h7;
    else if (op == 3'd1 && (f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) ill = 1;
    else if (op == 3'd1) code = tbl[f3];
    else ill = 1;
  endfunction

  task automatic model();
    logic [3:0] c;
    bit i;
    int n;
    if (flush_i) begin
      m_left = 0; m_vld = 0;
    end else if (valid_i && m_left == 0) begin
      ref_dec(alu_op_i, funct7_i, funct3_i, c, i, n);
      m_code = c; m_ill = i; m_left = n; m_vld = (n == 0);
    end else if (m_left > 0) begin
      m_left--; m_vld = (m_left == 0);
    end else m_vld = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("op_valid", op_valid_o, m_vld);
    chk("busy", busy_o, m_left > 0);
    chk("ready", ready_o, m_left == 0);
    chk("code", alu_operation_o, m_code);
    chk("illegal", illegal_o, m_ill);
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3);
    valid_i = v; alu_op_i = op; funct7_i = f7; funct3_i = f3;
  endtask

  initial begin
    #2;
    chk("rst_code", alu_operation_o, 4'h0);
    chk("rst_valid", op_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_ready", ready_o, 1);
    #6 reset = 1'b1;
    // MUL encoding: decoded by dut, illegal in the ENABLE_M=0 instance
    drive(1, 3'd0, 7'h01, 3'd0);
    step();
    chk("nom_ill", i2, 1);
    chk("nom_code", c2, 4'h0);
    chk("nom_valid", v2, 1);
    chk("nom_busy", b2, 0);
    drive(0, 3'd0, 7'h00, 3'd0);
    repeat (5) step();
    drive(1, 3'd0, 7'h00, 3'd6);
    step();
    chk("or_code", alu_operation_o, 4'h1);
    chk("or_valid", op_valid_o, 1);
    chk("or_ready", ready_o, 1);
    drive(1, 3'd0, 7'h01, 3'd4);
    step();
    drive(0, 3'd0, 7'h00, 3'd0);
    chk("div_busy", busy_o, 1);
    for (int k = 0; k < 31; k++) begin
      step();
      chk("div_busy", busy_o, 1);
      chk("div_notready", ready_o, 0);
    end
    step();
    chk("div_done_valid", op_valid_o, 1);
    chk("div_done_code", alu_operation_o, 4'hD);
    step();
    drive(1, 3'd0, 7'h01, 3'd0);
    step();
    drive(0, 3'd0, 7'h00, 3'd0);
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_ready", ready_o, 1);
    chk("flush_valid", op_valid_o, 0);
    repeat (4) begin
      step();
      chk("flush_novalid", op_valid_o, 0);
    end
    drive(1, 3'd0, 7'h20, 3'd6);
    step();
    chk("ill_flag", illegal_o, 1);
    chk("ill_code", alu_operation_o, 4'h0);
    chk("ill_valid", op_valid_o, 1);
    drive(1, 3'd0, 7'h01, 3'd1);
    step();
    drive(0, 3'd0, 7'h00, 3'd0);
    repeat (3) step();
    step();
    chk("b2b_mul_valid", op_valid_o, 1);
    chk("b2b_mul_code", alu_operation_o, 4'hC);
    drive(1, 3'd0, 7'h00, 3'd0);
    step();
    drive(0, 3'd0, 7'h00, 3'd0);
    chk("b2b_add_valid", op_valid_o, 1);
    chk("b2b_add_code", alu_operation_o, 4'h0);
    drive(1, 3'd0, 7'h01, 3'd5);
    step();
    drive(0, 3'd0, 7'h00, 3'd0);
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    chk("arst_code", alu_operation_o, 4'h0);
    chk("arst_valid", op_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_ill", illegal_o, 0);
    m_left = 0; m_vld = 0; m_code = 0; m_ill = 0;
    #2 reset = 1'b1;
    repeat (40) begin
      step();
      chk("arst_novalid", op_valid_o, 0);
    end
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: funct7_i = 7'h00;
        1: funct7_i = 7'h20;
        2: funct7_i = 7'h01;
        default: funct7_i = 7'($urandom);
      endcase
      valid_i = $urandom_range(0, 3) != 0;
      alu_op_i = 3'($urandom);
      funct3_i = 3'($urandom);
      flush_i = $urandom_range(0, 19) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4: busy cycles for multiply-class ops; legal range 1..255.
REQ-002 SHALL have parameter DIV_CYCLES, default 32: busy cycles for divide/remainder ops; legal range 1..255.
REQ-003 SHALL have parameter ENABLE_M, default 1: 1 = RV32M ops decoded; 0 = RV32M encodings flagged illegal.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush_i, input, 1: abort any in-flight op.
REQ-007 SHALL have port valid_i, input, 1: decode request present.
REQ-008 SHALL have port ready_o, output, 1: request can be accepted this cycle.
REQ-009 SHALL have port funct7_i, input, 7: full instruction funct7 field.
REQ-010 SHALL have port funct3_i, input, 3: instruction funct3 field.
REQ-011 SHALL have port alu_op_i, input, 3: main-control class; 000 R, 001 I-arith, 010 LUI, 011 branch, 100 load/store.
REQ-012 SHALL have port alu_operation_o, output, 4: registered ALU operation code.
REQ-013 SHALL have port op_valid_o, output, 1: alu_operation_o result is complete this cycle.
REQ-014 SHALL have port busy_o, output, 1: multi-cycle op in progress.
REQ-015 SHALL have port illegal_o, output, 1: last accepted request was an undecodable encoding.

Function
REQ-016 SHALL accept a request when valid_i=1 and ready_o=1 at a rising clk edge.
REQ-017 SHALL use op codes 0000 ADD, 0001 OR, 0010 AND, 0011 XOR, 0100 SUB, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1100 MUL, 1101 DIV, 1110 REM.
REQ-018 SHALL decode R-type funct7=0000000 by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-019 SHALL decode R-type funct7=0100000 as follows: funct3 000 gives SUB, 101 gives SRA, any other funct3 is illegal.
REQ-020 SHALL decode R-type funct7=0000001 (only when ENABLE_M=1) by funct3: 0xx MUL, 10x DIV, 11x REM.
REQ-021 SHALL decode I-arith like R-type funct7=0000000, except that funct3 101 with funct7=0100000 gives SRA and funct3 001/101 with any other non-zero funct7 is illegal.
REQ-022 SHALL decode LUI as ADD (0000), branch as SUB (0100), and load/store as ADD (0000), independent of funct7 and funct3.
REQ-023 SHALL treat every other combination, including alu_op_i 101..111, as illegal: alu_operation_o=0000, illegal_o=1, completion as for a single-cycle op.
REQ-024 SHALL have states IDLE, BUSY and DONE; ready_o=1 in IDLE and DONE, and ready_o=0 in BUSY.
REQ-025 SHALL handle an accepted single-cycle op (all except MUL/DIV/REM) as follows: register the code, illegal_o and op_valid_o=1 for exactly the next cycle, and stay in IDLE.
REQ-026 SHALL handle an accepted MUL/DIV/REM as follows: register the code, load the counter with MUL_CYCLES-1 or DIV_CYCLES-1, and go to BUSY with busy_o=1 and op_valid_o=0.
REQ-027 SHALL, in BUSY, decrement the counter each cycle; at counter=0, go to DONE (busy_o=0, op_valid_o=1 for one cycle).
REQ-028 SHALL set multi-cycle latency such that op_valid_o rises N+1 cycles after the accept edge (N = MUL_CYCLES or DIV_CYCLES).
REQ-029 SHALL allow a new request in DONE to be accepted in the same cycle (back-to-back), following REQ-025/026; with no request, DONE returns to IDLE.
REQ-030 SHALL hold alu_operation_o and illegal_o stable from the accept edge until the next accept.
REQ-031 SHALL give flush_i priority over valid_i in any state: next state IDLE, op_valid_o=0, busy_o=0, counter=0, alu_operation_o held.
REQ-032 SHALL, when valid_i=1 and ready_o=0, ignore the request (no sampling), and the requester SHALL hold it.
REQ-033 SHALL size the counter as 8 bits, and the counter SHALL never wrap below 0.

Reset
REQ-034 SHALL, while reset=0, immediately force state IDLE, alu_operation_o=0000, op_valid_o=0, busy_o=0, illegal_o=0, counter=0, ready_o=1.
REQ-035 SHALL, when reset is asserted mid-BUSY, abandon the op without asserting op_valid_o; the first edge after release behaves as IDLE.

Verification
REQ-036 SHALL verify: alu_op_i=000, funct7=0000000, funct3=110 accepted -> next cycle alu_operation_o=0001, op_valid_o=1, busy_o=0, ready_o stays 1.
REQ-037 SHALL verify: alu_op_i=000, funct7=0000001, funct3=100, DIV_CYCLES=32 -> busy_o=1 and ready_o=0 for 32 cycles, op_valid_o=1 on cycle 33 with code 1101.
REQ-038 SHALL verify: MUL accepted, then flush_i=1 on the third busy cycle -> next cycle IDLE, op_valid_o never asserted, ready_o=1.
REQ-039 SHALL verify: alu_op_i=000, funct7=0100000, funct3=110 -> illegal_o=1, code 0000, op_valid_o=1 next cycle; with ENABLE_M=0, funct7=0000001 also gives illegal_o=1.
REQ-040 SHALL verify: MUL accepted and an ADD presented in the DONE cycle -> ADD accepted, op_valid_o high two consecutive cycles with codes 1100 then 0000.
REQ-041 SHALL verify: reset pulled low mid-DIV -> outputs go to reset values without waiting for clk, and no op_valid_o pulse after release.
